// File: rtl/de2_switch_debouncer.sv
// de2_switch_debouncer
// Synchronises and debounces the DE2 slide switches ahead of the toggle-switch
// PIO. Each bit passes through a two-flop synchroniser. A shared prescaler
// produces a sample tick. A per-bit counter then requires a new level to hold
// for STABLE_TICKS consecutive ticks before it is accepted. On acceptance a
// one-cycle 'changed' strobe is raised for that bit.
module de2_switch_debouncer #(
  parameter int WIDTH        = 18,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] changed
);

  // Prescaler width: ceil(log2(TICK_DIV)). TICK_DIV >= 2 keeps this at least 1.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Stability counter width: ceil(log2(STABLE_TICKS+1)).
  localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;

  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [WIDTH-1:0]         s1_q, s1_d;
  logic [WIDTH-1:0]         s2_q, s2_d;
  logic [PW-1:0]            pcnt_q, pcnt_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         out_q, out_d;
  logic [WIDTH-1:0]         changed_q, changed_d;
  logic                     tick;

  // Synchroniser and prescaler next-state. The tick is high for the single
  // cycle in which the prescaler sits at its last count.
  always_comb begin
    s1_d   = sw_in;
    s2_d   = s1_q;
    tick   = (pcnt_q == PCNT_LAST);
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end

  // Per-bit qualification. A match with the current output always clears the
  // counter, so any bounce back restarts qualification. Otherwise each tick
  // advances the counter until the last count, where the new level is taken.
  always_comb begin
    cnt_d     = cnt_q;
    out_d     = out_q;
    changed_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick && (cnt_q[i] == CNT_LAST)) begin
        out_d[i]     = s2_q[i];
        cnt_d[i]     = '0;
        changed_d[i] = 1'b1;
      end else if (tick) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // State registers. The asynchronous reset clears everything, including any
  // qualification in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      pcnt_q    <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      changed_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      pcnt_q    <= pcnt_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      changed_q <= changed_d;
    end
  end

  assign out_port = out_q;
  assign changed  = changed_q;

endmodule
